// File: rtl/fir_decim_buffer_if.sv
// Sample stream interface for fir_decim_buffer: filtered input samples in,
// decimated samples out with a valid/ready handshake.
interface fir_decim_buffer_if #(
  parameter int unsigned DW = 8
);
  logic          din_valid;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  // master: the sample source plus the downstream consumer (e.g. a bench)
  modport master (
    output din_valid,
    output din,
    output dout_ready,
    input  dout,
    input  dout_valid
  );

  // slave: the decimating buffer itself
  modport slave (
    input  din_valid,
    input  din,
    input  dout_ready,
    output dout,
    output dout_valid
  );
endinterface

// File: rtl/fir_decim_buffer.sv
// Keeps every DECIM-th accepted sample from fir_filter and buffers it in a
// small synchronous FIFO behind a valid/ready port, with a sticky overflow flag.
module fir_decim_buffer #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DECIM = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_ovf,
  fir_decim_buffer_if.slave     bus,
  output logic [AW:0]           level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [AW:0]   LEVEL_MAX  = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [AW:0]   level_nxt;
  logic          full_nxt;
  logic          empty_nxt;
  logic          overflow_nxt;

  logic accept;
  logic keep;
  logic pop;
  logic push;
  logic drop;

  // Event decode: a pop frees a slot, so a kept sample is taken even when full
  always_comb begin
    accept = en & bus.din_valid;
    keep   = accept & (phase == '0);
    pop    = ~empty & bus.dout_ready;
    push   = keep & (~full | pop);
    drop   = keep & full & ~pop;
  end

  // Decimation phase advances on every accepted sample, kept or dropped
  always_comb begin
    phase_nxt = phase;
    if (accept) begin
      if (phase == PHASE_LAST) begin
        phase_nxt = '0;
      end else begin
        phase_nxt = phase + PW'(1);
      end
    end
  end

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    level_nxt  = level;
    if (push) begin
      wr_ptr_nxt = wr_ptr + AW'(1);
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_nxt = level + (AW + 1)'(1);
      2'b01:   level_nxt = level - (AW + 1)'(1);
      default: level_nxt = level;
    endcase
    full_nxt  = (level_nxt == LEVEL_MAX);
    empty_nxt = (level_nxt == '0);
  end

  // Set wins over clear so a drop in the clearing cycle is never lost
  always_comb begin
    overflow_nxt = overflow;
    if (drop) begin
      overflow_nxt = 1'b1;
    end else if (clr_ovf) begin
      overflow_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      phase    <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      phase    <= phase_nxt;
      level    <= level_nxt;
      full     <= full_nxt;
      empty    <= empty_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Storage is not reset; only entries behind the valid pointers are ever read
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  assign bus.dout       = empty ? '0 : mem[rd_ptr];
  assign bus.dout_valid = ~empty;

endmodule

// File: doc/fir_decim_buffer.md
Name: fir_decim_buffer

Overview:
Downstream stage of fir_filter. Consumes the 8-bit filtered sample stream and keeps every DECIM-th sample (decimation). Buffers kept samples in a small synchronous FIFO and presents them on a valid/ready output port to the next consumer, such as a bus capture or serializer. A sticky overflow flag reports samples lost because the consumer stalled.

Parameters:
DW, 8, sample width; matches fir_filter dout width.
DECIM, 4, decimation factor; legal range is 1..16, and 1 means pass-through.
DEPTH, 16, FIFO depth in samples; must be a power of 2, minimum 2.
AW, 4, log2(DEPTH).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
en  in  1  block enable; when 0, input samples are ignored.
din_valid  in  1  din holds a new filter output this cycle.
din  in  DW  filtered sample from fir_filter dout.
dout  out  DW  FIFO head sample.
dout_valid  out  1  dout holds a valid sample.
dout_ready  in  1  consumer accepts dout this cycle.
level  out  AW+1  number of samples currently stored, 0..DEPTH.
full  out  1  level == DEPTH.
empty  out  1  level == 0.
overflow  out  1  sticky flag: a kept sample was dropped.
clr_ovf  in  1  clears overflow.

Behaviour:
- Reset: at any rising edge with rst=1, the following are cleared:
  - read pointer, write pointer, level and phase counter go to 0;
  - overflow goes to 0; empty=1, full=0, dout_valid=0, dout=0.
  - FIFO memory contents are not cleared; they are treated as don't-care.
  - rst has priority over all other inputs. A reset mid-stream discards all buffered samples; dout_valid is 0 in the cycle after the reset edge.
- Input acceptance: a sample is accepted when en=1 and din_valid=1. Data is raw bits; no arithmetic is done on it.
- Phase counter (0..DECIM-1):
  - Increments on every accepted sample and wraps from DECIM-1 to 0.
  - The sample accepted while phase==0 is kept. The first accepted sample after reset is therefore always kept.
  - When en=0 or din_valid=0, the counter holds.
- Push: a kept sample is written at that rising edge if not full. Latency is 1 edge: a sample captured at edge N drives dout/dout_valid right after edge N when the FIFO was empty.
- Head read: dout is driven combinationally from mem[rd_ptr] and forced to 0 when empty. dout_valid = !empty.
- Pop: a sample is popped at an edge when dout_valid=1 and dout_ready=1. dout must stay stable while dout_valid=1 and dout_ready=0.
- Simultaneous events:
  - Push and pop in the same cycle: both occur and level is unchanged. This also applies when full, because the pop frees the slot and the push is not dropped.
  - Push while empty with dout_ready=1: only the push occurs (no pop, since dout_valid was 0). Level becomes 1.
- Overflow:
  - A kept sample arriving while full with no pop that cycle is dropped, and overflow is set to 1.
  - The phase counter advances regardless, so the decimation grid is preserved.
  - clr_ovf=1 clears overflow at the next edge. If a drop and clr_ovf occur in the same cycle, overflow is 1 (set wins).
- Pointers: read and write pointers are AW bits wide and wrap naturally. level is AW+1 bits and is updated by +1, -1 or 0. full and empty are decoded from level and registered consistently with it, with no extra cycle of lag.
- Non-kept samples (phase != 0) never touch the FIFO or overflow.

Test Plan:
1. DECIM=4, din=0x00..0x0F with din_valid=1 every cycle, en=1, dout_ready=1 -> dout sequence 0x00,0x04,0x08,0x0C; each dout_valid pulse lasts 1 cycle and starts the cycle after capture; level never exceeds 1.
2. dout_ready=0, stream din=0x00..0x3F -> level=16 and full=1 after kept sample 0x3C; overflow stays 0. Stream 0x40..0x43 with dout_ready=0 -> 0x40 is dropped and overflow=1. Then dout_ready=1 -> drains exactly 0x00,0x04,...,0x3C in order, then empty=1.
3. FIFO full, kept sample 0x50 arrives with dout_ready=1 in the same cycle -> level stays 16, overflow stays 0, 0x50 is the last sample drained.
4. Interleave en=0 cycles carrying din_valid=1 and din=0xAA -> 0xAA never appears on dout and the phase is unchanged; kept samples match run 1.
5. level=5 and phase=2, assert rst for 1 cycle -> next cycle level=0, dout_valid=0, overflow=0, dout=0; the first accepted sample after rst is kept.
6. With overflow=1, assert clr_ovf alone -> overflow=0 next edge. Assert clr_ovf in the same cycle as a new drop -> overflow remains 1.
